// File: rtl/rx_fifo_bus_if.sv
// rx_fifo_bus_if: bus register interface for the USB RX FIFO with pop, flush, sticky status and irq
module rx_fifo_bus_if #(
  parameter int         COUNT_W    = 16,
  parameter logic [7:0] THRESH_RST = 8'd1
) (
  input  logic               busClk,
  input  logic               rstSyncToBusClk,
  input  logic [2:0]         address,
  input  logic               writeEn,
  input  logic               strobe_i,
  input  logic               fifoSelect,
  input  logic [7:0]         busDataIn,
  output logic [7:0]         busDataOut,
  input  logic [7:0]         fifoDataIn,
  input  logic               fifoEmpty,
  input  logic               fifoOverflow,
  input  logic [COUNT_W-1:0] numElementsInFifo,
  output logic               fifoREn,
  output logic               forceEmpty,
  output logic               irq
);
  logic       rd, wr, rd_edge, wr_edge, level_flag;
  logic [15:0] count;
  logic       rd_prev_q, rd_prev_d, wr_prev_q, wr_prev_d;
  logic [2:0] ctrl_q, ctrl_d;
  logic [7:0] thresh_q, thresh_d;
  logic       over_q, over_d, under_q, under_d;
  logic       flush_q, flush_d, irq_q, irq_d;
  assign rd         = strobe_i & fifoSelect & ~writeEn;
  assign wr         = strobe_i & fifoSelect & writeEn;
  assign rd_edge    = rd & ~rd_prev_q;
  assign wr_edge    = wr & ~wr_prev_q;
  assign count      = 16'(numElementsInFifo);
  assign level_flag = count >= {8'b0, thresh_q};
  assign fifoREn    = rd_edge & (address == 3'd0) & ~fifoEmpty & ~rstSyncToBusClk;
  assign forceEmpty = flush_q;
  assign irq        = irq_q;
  // next-state: edge-qualified register writes, sticky set-over-clear, interrupt source
  always_comb begin
    rd_prev_d = rd;
    wr_prev_d = wr;
    ctrl_d    = (wr_edge && address == 3'd1) ? busDataIn[2:0] : ctrl_q;
    thresh_d  = (wr_edge && address == 3'd6) ? busDataIn : thresh_q;
    flush_d   = wr_edge && address == 3'd4 && busDataIn[0];
    over_d    = fifoOverflow | (over_q & ~(wr_edge && address == 3'd5 && busDataIn[2]));
    under_d   = (rd_edge && address == 3'd0 && fifoEmpty) |
                (under_q & ~(wr_edge && address == 3'd5 && busDataIn[3]));
    irq_d     = (ctrl_q[0] & level_flag) | (ctrl_q[1] & over_q) | (ctrl_q[2] & under_q);
  end
  // state registers with synchronous reset overriding any concurrent access
  always_ff @(posedge busClk) begin
    if (rstSyncToBusClk) begin
      rd_prev_q <= 1'b0;
      wr_prev_q <= 1'b0;
      ctrl_q    <= 3'b0;
      thresh_q  <= THRESH_RST;
      over_q    <= 1'b0;
      under_q   <= 1'b0;
      flush_q   <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      rd_prev_q <= rd_prev_d;
      wr_prev_q <= wr_prev_d;
      ctrl_q    <= ctrl_d;
      thresh_q  <= thresh_d;
      over_q    <= over_d;
      under_q   <= under_d;
      flush_q   <= flush_d;
      irq_q     <= irq_d;
    end
  end
  // read-data mux; empty FIFO reads as zero rather than stale head data
  always_comb begin
    busDataOut = 8'h00;
    case (address)
      3'd0: busDataOut = fifoEmpty ? 8'h00 : fifoDataIn;
      3'd1: busDataOut = {5'b0, ctrl_q};
      3'd2: busDataOut = count[15:8];
      3'd3: busDataOut = count[7:0];
      3'd4: busDataOut = {4'b0, under_q, over_q, level_flag, fifoEmpty};
      3'd6: busDataOut = thresh_q;
      default: busDataOut = 8'h00;
    endcase
  end
endmodule
